// File: rtl/fp32_pkg.sv
// Shared FP32 constants, FSM state encoding and field helpers for the
// sequential multiplier.
package fp32_pkg;

    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        PACK = 2'd3
    } state_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp32_mul_seq_if.sv
// Operand/result bus between the arithmetic unit and the FP32 multiplier.
interface fp32_mul_seq_if;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        underflow;
    logic        overflow;

    modport master (
        output start, a, b,
        input  busy, done, out, underflow, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, out, underflow, overflow
    );

endinterface

// File: rtl/mant_mul_shiftadd.sv
// Iterative W x W -> 2W unsigned multiplier: one multiplier bit per step,
// LSB first, with the partial product shifted right each step.
module mant_mul_shiftadd #(
    parameter int W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [W-1:0]     mcand_in,
    input  logic [W-1:0]     mplier_in,
    output logic [2*W-1:0]   product,
    output logic             ready
);

    localparam int            CNT_W    = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(W);

    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [CNT_W-1:0] count;
    logic [W:0]       sum;

    // Add into the top half; the carry lands in bit 2W-1 after the shift.
    always_comb begin
        sum = {1'b0, product[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : '0);
    end

    // NOTE: state registers use non-blocking assignments and an asynchronous
    // active-low reset so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            count   <= '0;
        end else if (load) begin
            mcand   <= mcand_in;
            mplier  <= mplier_in;
            product <= '0;
            count   <= '0;
        end else if (step && !ready) begin
            product <= {sum, product[W-1:1]};
            mplier  <= mplier >> 1;
            count   <= count + 1'b1;
        end
    end

    assign ready = (count == CNT_DONE);

endmodule

// File: rtl/fp32_mul_seq.sv
// Sequential FP32 multiplier: fixed 26-cycle start-to-done latency,
// truncating rounding, denormals flushed to zero.
module fp32_mul_seq
    import fp32_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int BIAS   = FP_BIAS
) (
    input logic           clk,
    input logic           rst_n,
    fp32_mul_seq_if.slave bus
);

    localparam int PROD_W = 2 * MANT_W;
    localparam int FRAC_W = MANT_W - 1;
    localparam int CNT_W  = $clog2(MANT_W);
    localparam int E_W    = EXP_W + 2;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(MANT_W - 1);
    localparam logic signed [E_W-1:0] E_MAX_S   = E_W'(FP_EXP_MAX);
    localparam logic signed [E_W-1:0] E_ZERO_S  = '0;
    localparam logic [EXP_W-1:0]      EXP_ONES  = '1;

    state_t                  state_q, state_d;
    logic                    sign_q;
    logic signed [E_W-1:0]   exp_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [FRAC_W-1:0]       frac_q;
    logic                    nan_q, inf_q, zero_q;

    logic                    accept;
    logic                    a_inf, b_inf, a_zero, b_zero;
    logic [PROD_W-1:0]       mant_prod;
    logic                    mul_ready;
    logic                    unused_mul;
    logic [31:0]             out_d;
    logic                    unf_d, ovf_d;

    // A start seen while done is still pulsing belongs to the finished op.
    assign accept = (state_q == IDLE) && bus.start && !bus.done;
    assign a_inf  = (fp_exp(bus.a) == EXP_ONES);
    assign b_inf  = (fp_exp(bus.b) == EXP_ONES);
    assign a_zero = (fp_exp(bus.a) == '0);
    assign b_zero = (fp_exp(bus.b) == '0);
    assign bus.busy = (state_q != IDLE);

    mant_mul_shiftadd #(.W(MANT_W)) u_mant (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (state_q == MUL),
        .mcand_in  ({~a_zero, fp_frac(bus.a)}),
        .mplier_in ({~b_zero, fp_frac(bus.b)}),
        .product   (mant_prod),
        .ready     (mul_ready)
    );

    // Low product bits are dropped by truncation; the FSM counts steps itself.
    assign unused_mul = ^{mul_ready, mant_prod[PROD_W-FRAC_W-3:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: combinational blocks assign every output a default first so no
    // path through the case/if tree can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = MUL;
            MUL:  if (cnt_q == CNT_LAST) state_d = NORM;
            NORM: state_d = PACK;
            PACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            cnt_q  <= '0;
            frac_q <= '0;
            nan_q  <= 1'b0;
            inf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    sign_q <= fp_sign(bus.a) ^ fp_sign(bus.b);
                    exp_q  <= E_W'(fp_exp(bus.a)) + E_W'(fp_exp(bus.b)) - E_W'(BIAS);
                    nan_q  <= (a_inf && b_zero) || (b_inf && a_zero);
                    inf_q  <= a_inf || b_inf;
                    zero_q <= a_zero || b_zero;
                    cnt_q  <= '0;
                end
                MUL: cnt_q <= cnt_q + 1'b1;
                NORM: begin
                    if (mant_prod[PROD_W-1]) begin
                        frac_q <= mant_prod[PROD_W-2 -: FRAC_W];
                        exp_q  <= exp_q + 1'b1;
                    end else begin
                        frac_q <= mant_prod[PROD_W-3 -: FRAC_W];
                    end
                end
                default: ;
            endcase
        end
    end

    // Result selection, highest-priority special case first.
    always_comb begin
        out_d = {sign_q, exp_q[EXP_W-1:0], frac_q};
        unf_d = 1'b0;
        ovf_d = 1'b0;
        if (nan_q) begin
            out_d = FP_QNAN;
        end else if (inf_q) begin
            out_d = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (zero_q) begin
            out_d = {sign_q, 31'b0};
        end else if (exp_q >= E_MAX_S) begin
            out_d = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (exp_q <= E_ZERO_S) begin
            out_d = {sign_q, 31'b0};
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= '0;
            bus.underflow <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= (state_q == PACK);
            if (state_q == PACK) begin
                bus.out       <= out_d;
                bus.underflow <= unf_d;
                bus.overflow  <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Self-checking bench for fp32_mul_seq: vector table through a scoreboard,
// plus protocol sequences (restart while busy, start on done, async abort).
module tb_fp32_mul_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    fp32_mul_seq_if ifc ();

    fp32_mul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        unf;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic        unf;
        logic        ovf;
        int          e0;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard side: every done pops one expectation and checks latency.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(ifc.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_out", ifc.out, e.out);
                check("result_underflow", 32'(ifc.underflow), 32'(e.unf));
                check("result_overflow", 32'(ifc.overflow), 32'(e.ovf));
                check("latency", 32'(cyc - e.e0), 32'd26);
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] out, input logic unf, input logic ovf);
        @(negedge clk);
        ifc.a     = a;
        ifc.b     = b;
        ifc.start = 1'b1;
        sb.push_back('{out: out, unf: unf, ovf: ovf, e0: cyc + 1});
        @(negedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.a     = $urandom;
        ifc.b     = $urandom;
    endtask

    // Waits for the scoreboard to drain; returns how many sampled cycles had busy=1.
    task automatic wait_done(input string name, input int restart_at, output int busy_cnt);
        int waited = 0;
        busy_cnt = 0;
        while (sb.size() > 0 && waited < 60) begin
            if (ifc.busy === 1'b1) busy_cnt++;
            if (waited == restart_at) begin
                ifc.start = 1'b1;
                ifc.a     = 32'h3F80_0000;
                ifc.b     = 32'h4000_0000;
            end else begin
                ifc.start = 1'b0;
            end
            @(negedge clk);
            #1;
            waited++;
        end
        ifc.start = 1'b0;
        if (sb.size() > 0) begin
            check({name, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=%0d required=finished", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int busy_cnt;

        vecs.push_back('{32'h3F70_0000, 32'h3E30_0000, 32'h3E25_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h3F50_0000, 32'hBED0_0000, 32'hBEA9_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0001, 1'b0, 1'b0});
        vecs.push_back('{32'h7F50_0000, 32'h4080_0000, 32'h7F80_0000, 1'b0, 1'b1});
        vecs.push_back('{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0});
        vecs.push_back('{32'hBFC0_0000, 32'hBFC0_0000, 32'h4010_0000, 1'b0, 1'b0});
        vecs.push_back('{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b1});
        vecs.push_back('{32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0, 1'b1});
        vecs.push_back('{32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b1});
        vecs.push_back('{32'h7F7F_FFFF, 32'h3FFF_FFFF, 32'h7F80_0000, 1'b0, 1'b1});
        vecs.push_back('{32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h0080_0000, 32'h3F7F_FFFF, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{32'h8080_0000, 32'h3F00_0000, 32'h8000_0000, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0});

        rst_n     = 1'b0;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", 32'(ifc.busy), 32'd0);
        check("reset_done", 32'(ifc.done), 32'd0);
        check("reset_out", ifc.out, 32'd0);
        check("reset_flags", 32'({ifc.underflow, ifc.overflow}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].unf, vecs[i].ovf);
            wait_done($sformatf("vec%0d", i), -1, busy_cnt);
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 32'd26);
        end

        // Result holds after done until the next operation.
        repeat (3) @(negedge clk);
        check("hold_out", ifc.out, 32'h0000_0000);
        check("hold_done_low", 32'(ifc.done), 32'd0);

        // A second start while busy must not relatch operands or add a done.
        launch(32'h3F70_0000, 32'h3E30_0000, 32'h3E25_0000, 1'b0, 1'b0);
        wait_done("restart_busy", 5, busy_cnt);
        check("restart_busy_cycles", 32'(busy_cnt), 32'd26);

        // Start raised in the done cycle is ignored.
        launch(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0);
        wait_done("start_on_done", -1, busy_cnt);
        check("start_on_done_seen_done", 32'(ifc.done), 32'd1);
        ifc.start = 1'b1;
        ifc.a     = 32'h3F80_0000;
        ifc.b     = 32'h3F80_0000;
        @(negedge clk);
        #1;
        ifc.start = 1'b0;
        check("start_on_done_not_busy", 32'(ifc.busy), 32'd0);
        repeat (30) @(negedge clk);
        check("start_on_done_out_kept", ifc.out, 32'h40C0_0000);

        // Abort mid-operation after an overflow result so the reset clears real state.
        launch(32'h7F50_0000, 32'h4080_0000, 32'h7F80_0000, 1'b0, 1'b1);
        wait_done("pre_abort", -1, busy_cnt);
        launch(32'h3F70_0000, 32'h3E30_0000, 32'h3E25_0000, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        #1;
        check("abort_busy_before", 32'(ifc.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_busy", 32'(ifc.busy), 32'd0);
        check("abort_done", 32'(ifc.done), 32'd0);
        check("abort_out", ifc.out, 32'd0);
        check("abort_overflow", 32'(ifc.overflow), 32'd0);
        check("abort_underflow", 32'(ifc.underflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_done_out", ifc.out, 32'd0);

        launch(32'h3F50_0000, 32'hBED0_0000, 32'hBEA9_0000, 1'b0, 1'b0);
        wait_done("after_abort", -1, busy_cnt);
        check("after_abort_busy_cycles", 32'(busy_cnt), 32'd26);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
